// File: rtl/seq_pattern_detect_if.sv
// Serial pattern detector bus: stream input, config and match outputs.
// PATTERN_MASK_EN adds a per-bit mask.
interface seq_pattern_detect_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  logic             data_in;
  logic             valid_in;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             clear;
`ifdef PATTERN_MASK_EN
  logic [PAT_W-1:0] mask;
`endif
  logic             data_out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
`ifdef PATTERN_MASK_EN
    output mask,
`endif
    output data_in,
    output valid_in,
    output pattern,
    output overlap,
    output clear,
    input  data_out,
    input  match_cnt,
    input  cnt_sat
  );

  modport slave (
`ifdef PATTERN_MASK_EN
    input  mask,
`endif
    input  data_in,
    input  valid_in,
    input  pattern,
    input  overlap,
    input  clear,
    output data_out,
    output match_cnt,
    output cnt_sat
  );
endinterface

// File: rtl/seq_pattern_detect.sv
// Programmable serial pattern detector with saturating match counter.
// Macro PATTERN_MASK_EN enables don't-care bits via bus.mask.
module seq_pattern_detect #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_pattern_detect_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MIN = FW'(PAT_W - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] diff;
  logic [FW-1:0]    fill;
  logic             beat;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  // Candidate window and match decision for the current beat.
  always_comb begin
    cand = {hist[PAT_W-2:0], bus.data_in};
    diff = cand ^ bus.pattern;
`ifdef PATTERN_MASK_EN
    diff = diff & bus.mask;
`endif
    beat = bus.valid_in & ~bus.clear;
    hit  = beat && (fill >= FILL_MIN) &&
           (diff == '0);
    cnt_nxt = (cnt_q == CNT_MAX) ?
              cnt_q : cnt_q + CNT_W'(1);
  end

  // History, fill level, match pulse and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.clear) begin
      hist  <= '0;
      fill  <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (beat) begin
      hist  <= cand;
      out_q <= hit;
      if (hit && !bus.overlap)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FW'(1);
      if (hit) begin
        cnt_q <= cnt_nxt;
        sat_q <= (cnt_nxt == CNT_MAX);
      end
    end else begin
      out_q <= 1'b0;
    end
  end

  assign bus.data_out  = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_pattern_detect.sv
// Scoreboard bench for seq_pattern_detect: a 3-bit/8-bit instance
// and a 2-bit/2-bit instance for counter saturation.
module tb_seq_pattern_detect;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_detect_if #(.PAT_W(3), .CNT_W(8)) ia ();
  seq_pattern_detect_if #(.PAT_W(2), .CNT_W(2)) ib ();

  seq_pattern_detect #(.PAT_W(3), .CNT_W(8)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  seq_pattern_detect #(.PAT_W(2), .CNT_W(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  typedef struct {
    bit o;
    int c;
    bit s;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  // reference model: shift of received bits plus count of bits seen
  // since the last reset, clear or non-overlapping match
  logic [31:0] m_sh[2];
  int          m_n[2];
  int          m_cnt[2];
  bit          m_out[2];
  logic [31:0] m_pat[2];
  logic [31:0] m_msk[2];
  bit          m_ovl[2];
  int          m_pw[2];
  int          m_max[2];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sh[k] = '0;
      m_n[k] = 0;
      m_cnt[k] = 0;
      m_out[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int s, input bit d, input bit v,
                            input bit clr);
    logic [31:0] lm;
    bit hit;
    lm = (m_pw[s] == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_pw[s]) - 32'd1);
    if (clr) begin
      m_sh[s] = '0;
      m_n[s] = 0;
      m_out[s] = 1'b0;
      m_cnt[s] = 0;
    end else if (v) begin
      m_sh[s] = {m_sh[s][30:0], d};
      if (m_n[s] < 32) m_n[s]++;
      hit = (m_n[s] >= m_pw[s]) &&
            (((m_sh[s] ^ m_pat[s]) & m_msk[s] & lm) == 0);
      m_out[s] = hit;
      if (hit) begin
        if (m_cnt[s] < m_max[s]) m_cnt[s]++;
        if (!m_ovl[s]) m_n[s] = 0;
      end
    end else begin
      m_out[s] = 1'b0;
    end
  endtask

  task automatic cfg(input int s, input logic [31:0] pat,
                     input bit ovl, input logic [31:0] msk);
    @(negedge clk);
    m_pat[s] = pat;
    m_ovl[s] = ovl;
    m_msk[s] = msk;
    if (s == 0) begin
      ia.pattern = pat[2:0];
      ia.overlap = ovl;
`ifdef PATTERN_MASK_EN
      ia.mask = msk[2:0];
`endif
    end else begin
      ib.pattern = pat[1:0];
      ib.overlap = ovl;
`ifdef PATTERN_MASK_EN
      ib.mask = msk[1:0];
`endif
    end
  endtask

  task automatic step(input int s, input bit d, input bit v,
                      input bit clr);
    exp_t e;
    exp_t a;
    @(negedge clk);
    ia.data_in = d;
    ia.valid_in = (s == 0) ? v : 1'b0;
    ia.clear = (s == 0) ? clr : 1'b0;
    ib.data_in = d;
    ib.valid_in = (s == 1) ? v : 1'b0;
    ib.clear = (s == 1) ? clr : 1'b0;
    model_step(s, d, v, clr);
    m_out[1-s] = 1'b0;
    e.o = m_out[s];
    e.c = m_cnt[s];
    e.s = (m_cnt[s] == m_max[s]);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (s == 0) begin
      a.o = ia.data_out;
      a.c = int'(ia.match_cnt);
      a.s = ia.cnt_sat;
    end else begin
      a.o = ib.data_out;
      a.c = int'(ib.match_cnt);
      a.s = ib.cnt_sat;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check(s == 0 ? "a_data_out" : "b_data_out", int'(a.o), int'(e.o));
      check(s == 0 ? "a_match_cnt" : "b_match_cnt", a.c, e.c);
      check(s == 0 ? "a_cnt_sat" : "b_cnt_sat", int'(a.s), int'(e.s));
    end
    ia.valid_in = 1'b0;
    ib.valid_in = 1'b0;
    ia.clear = 1'b0;
    ib.clear = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_data_out", int'(ia.data_out), 0);
    check("rst_match_cnt", int'(ia.match_cnt), 0);
    check("rst_cnt_sat", int'(ia.cnt_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stream_a(input logic [2:0] bits);
    for (int i = 2; i >= 0; i--) step(0, bits[i], 1'b1, 1'b0);
  endtask

  initial begin
    ia.data_in = 1'b0; ia.valid_in = 1'b0; ia.clear = 1'b0;
    ia.pattern = '0; ia.overlap = 1'b0;
    ib.data_in = 1'b0; ib.valid_in = 1'b0; ib.clear = 1'b0;
    ib.pattern = '0; ib.overlap = 1'b0;
`ifdef PATTERN_MASK_EN
    ia.mask = '1;
    ib.mask = '1;
`endif
    m_pw[0] = 3; m_max[0] = 255;
    m_pw[1] = 2; m_max[1] = 3;
    model_reset();

    // reset state
    #2;
    check("init_a_data_out", int'(ia.data_out), 0);
    check("init_a_match_cnt", int'(ia.match_cnt), 0);
    check("init_b_match_cnt", int'(ib.match_cnt), 0);
    check("init_b_cnt_sat", int'(ib.cnt_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // overlapping 0,1,0,1,0 -> two pulses
    cfg(0, 32'b010, 1'b1, 32'hFFFF_FFFF);
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    check("ovl_total", int'(ia.match_cnt), 2);

    // non-overlapping -> one pulse
    cfg(0, 32'b010, 1'b0, 32'hFFFF_FFFF);
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    check("novl_total", int'(ia.match_cnt), 1);

    // gaps between bits never break the partial pattern
    cfg(0, 32'b010, 1'b1, 32'hFFFF_FFFF);
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0);
    check("gap_total", int'(ia.match_cnt), 1);

    // reset mid-pattern loses history
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    pulse_reset();
    step(0, 1'b0, 1'b1, 1'b0);
    check("rst_no_pulse", int'(ia.data_out), 0);
    stream_a(3'b010);
    check("rst_then_match", int'(ia.match_cnt), 1);

    // clear beats a completing bit
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b1);
    check("clear_wins_cnt", int'(ia.match_cnt), 0);
    check("clear_wins_out", int'(ia.data_out), 0);

    // saturation: pattern 11, six ones, 2-bit counter
    cfg(1, 32'b11, 1'b1, 32'hFFFF_FFFF);
    step(1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1, 1'b1, 1'b1, 1'b0);
    check("sat_cnt", int'(ib.match_cnt), 3);
    check("sat_flag", int'(ib.cnt_sat), 1);

`ifdef PATTERN_MASK_EN
    // middle bit don't-care
    cfg(0, 32'b010, 1'b0, 32'b101);
    step(0, 1'b0, 1'b0, 1'b1);
    stream_a(3'b000);
    stream_a(3'b010);
    stream_a(3'b011);
    check("mask_total", int'(ia.match_cnt), 2);
`endif

    // random traffic with mid-run pattern/overlap changes
    cfg(0, 32'b110, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 60; i++) begin
      if (i == 30) cfg(0, 32'b101, 1'b0, 32'hFFFF_FFFF);
      step(0, 1'($urandom % 2), ($urandom % 4) != 0,
           ($urandom % 16) == 0);
    end
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_pattern_detect.md
Name: seq_pattern_detect

Overview:
Parametrised serial pattern detector. It watches a qualified one-bit stream for a run-time programmable PAT_W-bit pattern and emits a registered one-cycle match pulse. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits on serial monitor and sync-word paths, replacing fixed-pattern, hard-coded-FSM detectors.

Parameters:
PAT_W, 3, pattern length in bits; legal range 2..32.
CNT_W, 8, width of the match counter; legal range 1..32.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
data_in  in  1  serial data bit.
valid_in  in  1  data_in is sampled only when this is 1.
pattern  in  PAT_W  target pattern; MSB is the first bit received; sampled every cycle.
overlap  in  1  1 = overlapping matches allowed; 0 = history is discarded after a match.
clear  in  1  synchronous flush of history, output and counter.
data_out  out  1  registered match pulse.
match_cnt  out  CNT_W  saturating count of matches.
cnt_sat  out  1  1 while match_cnt is all-ones.

Behaviour:
- Reset (rst_n=0): data_out=0, match_cnt=0, cnt_sat=0, history=0, fill=0. Effect is immediate; there is no clock dependency.
- State:
  - hist[PAT_W-1:0]: shift register; the newest bit is at the LSB.
  - fill: count of valid bits held, range 0..PAT_W.
- Beat = cycle with valid_in=1 and clear=0.
  - On a beat: cand = {hist[PAT_W-2:0], data_in}; hist <= cand; fill <= min(fill+1, PAT_W).
- Match on a beat: (fill >= PAT_W-1) and (cand == pattern).
  - data_out=1 in the next cycle only; one-cycle latency from the completing bit.
  - match_cnt increments unless it is already all-ones, in which case it holds. cnt_sat is registered alongside it.
  - overlap=0: fill <= 0 on the same edge, so the next match needs PAT_W fresh bits.
  - overlap=1: fill stays PAT_W, so matches can complete on consecutive beats. Example: pattern 11, stream 111 gives 2 pulses.
- Non-beat cycle (valid_in=0): hist and fill hold; data_out <= 0. Gaps never break a partial pattern.
- clear=1: fill <= 0, hist <= 0, data_out <= 0, match_cnt <= 0, cnt_sat <= 0.
  - clear wins over a simultaneous valid_in; that bit is discarded.
- Pattern changes take effect on the next beat and are compared against the existing history. Software should assert clear when it reprograms the pattern.
- data_out is never combinational from data_in.
- Reset mid-pattern: partial history is lost, and a full PAT_W bits are needed after release.

Optional Feature:
Macro PATTERN_MASK_EN.
- Defined:
  - Adds input port mask (PAT_W). A mask bit of 0 makes the corresponding pattern bit don't-care.
  - Match requires ((cand ^ pattern) & mask) == 0, plus the fill condition.
  - mask all-zero matches every beat once fill >= PAT_W-1.
- Undefined: no mask port; exact compare as above.

Test Plan:
- PAT_W=3, pattern=010, overlap=1, stream 0,1,0,1,0 on consecutive beats -> data_out high in the cycles after beats 3 and 5; match_cnt=2.
- Same stream with overlap=0 -> single pulse after beat 3; match_cnt=1.
- Pattern 010 with valid_in=0 gaps of 1-3 cycles between bits -> one pulse, one cycle after the third valid bit; data_out stays 0 during gaps.
- Stream 0,1, then rst_n low for 1 cycle, then 0 -> no pulse. Then 0,1,0 -> pulse and match_cnt=1. Also assert clear concurrently with a completing bit -> no pulse and match_cnt=0.
- CNT_W=2, overlap=1, pattern 11, stream of 6 ones -> 5 pulses; match_cnt counts 1,2,3 then holds 3; cnt_sat=1 from the third match.
- PATTERN_MASK_EN defined, pattern=010, mask=101, streams 000 and 010 -> a pulse for each. Stream 011 -> no pulse.
